// File: rtl/serial_adder_if.sv
// serial_adder_if: operand/result bundle for the bit-serial adder.
// Optional feature macro: SERIAL_ADDER_OVF_EN adds the ovf signal.
//
// Handshake: the requester drives start together with op_a/op_b/cin. The
// request is taken on a rising clk edge where start=1 and ready=1, and the
// operands are captured on that edge only. done pulses for exactly one cycle
// when result/cout (and ovf) are valid. Those outputs then hold until the
// next accepted start.
interface serial_adder_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic [WIDTH-1:0] op_a;
    logic [WIDTH-1:0] op_b;
    logic             cin;
    logic             ready;
    logic             done;
    logic [WIDTH-1:0] result;
    logic             cout;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf;

    modport master (
        output start, op_a, op_b, cin,
        input  ready, done, result, cout, ovf
    );
    modport slave (
        input  start, op_a, op_b, cin,
        output ready, done, result, cout, ovf
    );
`else
    modport master (
        output start, op_a, op_b, cin,
        input  ready, done, result, cout
    );
    modport slave (
        input  start, op_a, op_b, cin,
        output ready, done, result, cout
    );
`endif
endinterface

// File: rtl/serial_adder.sv
// serial_adder: adds two WIDTH-bit operands plus carry-in one bit per clock,
// LSB first. The result appears WIDTH+1 edges after the accepted start,
// counting the start edge.
// Optional feature macro: SERIAL_ADDER_OVF_EN adds a registered signed-overflow flag.
// state_o exposes the FSM state: 0=IDLE, 1=RUN, 2=DONE.
module serial_adder #(
    parameter int WIDTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    serial_adder_if.slave bus,
    output logic [1:0]    state_o
);
    // A bit counter must exist even for WIDTH=1.
    localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t           state_q;
    logic [WIDTH-1:0] a_q;
    logic [WIDTH-1:0] b_q;
    logic [WIDTH-1:0] result_q;
    logic [WIDTH-1:0] result_d;
    logic [CW-1:0]    cnt_q;
    logic             carry_q;
    logic             carry_d;
    logic             sum_d;
    logic             last_d;
    logic             ready_q;
    logic             done_q;
    logic             cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    logic             ovf_q;
`endif

    // Full-adder slice on the operand LSBs; the new sum bit enters result from the MSB side.
    always_comb begin
        sum_d             = a_q[0] ^ b_q[0] ^ carry_q;
        carry_d           = (a_q[0] & b_q[0]) | (carry_q & (a_q[0] ^ b_q[0]));
        result_d          = result_q >> 1;
        result_d[WIDTH-1] = sum_d;
        last_d            = (cnt_q == CW'(WIDTH - 1));
    end

    // FSM plus datapath: capture on accept, one bit per RUN edge, one-cycle DONE.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= IDLE;
            a_q      <= '0;
            b_q      <= '0;
            result_q <= '0;
            cnt_q    <= '0;
            carry_q  <= 1'b0;
            ready_q  <= 1'b1;
            done_q   <= 1'b0;
            cout_q   <= 1'b0;
`ifdef SERIAL_ADDER_OVF_EN
            ovf_q    <= 1'b0;
`endif
        end else begin
            case (state_q)
                // IDLE and DONE both accept a new request; ready_q is 1 in both.
                IDLE, DONE: begin
                    done_q <= 1'b0;
                    if (bus.start) begin
                        a_q     <= bus.op_a;
                        b_q     <= bus.op_b;
                        carry_q <= bus.cin;
                        cnt_q   <= '0;
                        ready_q <= 1'b0;
                        state_q <= RUN;
                    end else begin
                        ready_q <= 1'b1;
                        state_q <= IDLE;
                    end
                end
                RUN: begin
                    a_q      <= a_q >> 1;
                    b_q      <= b_q >> 1;
                    carry_q  <= carry_d;
                    result_q <= result_d;
                    cnt_q    <= cnt_q + CW'(1);
                    if (last_d) begin
                        cout_q  <= carry_d;
`ifdef SERIAL_ADDER_OVF_EN
                        // carry_q is the carry into the MSB on this edge.
                        ovf_q   <= carry_q ^ carry_d;
`endif
                        ready_q <= 1'b1;
                        done_q  <= 1'b1;
                        state_q <= DONE;
                    end
                end
                default: begin
                    ready_q <= 1'b1;
                    done_q  <= 1'b0;
                    state_q <= IDLE;
                end
            endcase
        end
    end

    assign bus.ready  = ready_q;
    assign bus.done   = done_q;
    assign bus.result = result_q;
    assign bus.cout   = cout_q;
`ifdef SERIAL_ADDER_OVF_EN
    assign bus.ovf    = ovf_q;
`endif
    assign state_o    = state_q;

endmodule
